// File: rtl/mux_arb_pkg.sv
// Shared definitions for the 4-way round-robin mux arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mux_arb_pkg;

    localparam int N_REQ = 4;   // requesters sharing the mux
    localparam int IDX_W = 2;   // width of a requester index

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // LAST resets to the highest index so that requester 0 wins the first pick.
    localparam logic [IDX_W-1:0] LAST_RST = 2'd3;

endpackage

// File: rtl/mux_arb_rr_pick.sv
// Round-robin picker: first requester at or after LAST+1 (wrapping, LAST itself searched last).
// Latency: purely combinational.
// Backpressure: none; VALID=0 when no request bit is set.
//   REQ   : request vector
//   LAST  : index of the most recent grant
//   VALID : at least one request present
//   IDX   : picked index (meaningful only when VALID=1)
module rr_pick
    import mux_arb_pkg::*;
(
    input  logic [N_REQ-1:0] REQ,
    input  logic [IDX_W-1:0] LAST,
    output logic             VALID,
    output logic [IDX_W-1:0] IDX
);

    // Walk offsets from farthest (LAST itself) to nearest (LAST+1); the last
    // hit written is the nearest one, which is the round-robin winner.
    always_comb begin
        logic [IDX_W-1:0] cand;
        VALID = 1'b0;
        IDX   = LAST;
        cand  = LAST;
        for (int k = N_REQ; k >= 1; k--) begin
            cand = LAST + IDX_W'(k);
            if (REQ[cand]) begin
                VALID = 1'b1;
                IDX   = cand;
            end
        end
    end

endmodule

// File: rtl/mux_arb.sv
// 4-way round-robin arbiter driving a shared mux (one-hot GNT, select S, enable EN).
// Latency: 1 cycle, all outputs registered; REQ sampled at an edge shows on GNT after it.
// Backpressure: a grant is held while its REQ stays high; with MUX_ARB_TIMEOUT_EN defined
//   a holder is rotated out after HOLD_MAX cycles if another requester is waiting.
//   CLK  : clock, rising edge      RST  : synchronous active-high reset
//   REQ  : request vector          GNT  : one-hot grant, 0 when idle
//   EN   : |GNT                    S    : index of granted requester
//   BUSY : FSM is in GRANT
module mux_arb
    import mux_arb_pkg::*;
#(
    parameter int HOLD_MAX = 8,
    parameter int CNT_W    = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [N_REQ-1:0] REQ,
    output logic [N_REQ-1:0] GNT,
    output logic             EN,
    output logic [IDX_W-1:0] S,
    output logic             BUSY
);

    state_t           state;
    logic [IDX_W-1:0] last;      // equals the current grant index while in GRANT
    logic             pick_vld;
    logic [IDX_W-1:0] pick_idx;
    logic             keep_cur;

    rr_pick u_rr_pick (
        .REQ   (REQ),
        .LAST  (last),
        .VALID (pick_vld),
        .IDX   (pick_idx)
    );

`ifdef MUX_ARB_TIMEOUT_EN
    logic [CNT_W-1:0] hold_cnt;
    logic             at_limit;
    logic             others_pending;

    assign at_limit       = (hold_cnt == CNT_W'(HOLD_MAX - 1));
    assign others_pending = |(REQ & ~(N_REQ'(1) << last));
    // Holder keeps the mux unless its hold window is spent and someone else waits.
    assign keep_cur       = REQ[last] && !(at_limit && others_pending);
`else
    // Hold window does not exist in this build; parameters are tied off here.
    logic [CNT_W-1:0] unused_cfg;
    assign unused_cfg = CNT_W'(HOLD_MAX);
    assign keep_cur   = REQ[last];
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            GNT   <= '0;
            EN    <= 1'b0;
            S     <= '0;
            BUSY  <= 1'b0;
            last  <= LAST_RST;
`ifdef MUX_ARB_TIMEOUT_EN
            hold_cnt <= '0;
`endif
        end else if (state == GRANT && keep_cur) begin
`ifdef MUX_ARB_TIMEOUT_EN
            if (!at_limit) begin
                hold_cnt <= hold_cnt + CNT_W'(1);
            end
`endif
        end else if (pick_vld) begin
            // Covers first grant from IDLE, hand-off on REQ drop and timeout
            // rotation; picking relative to the current holder skips it when
            // another requester is pending.
            state <= GRANT;
            GNT   <= N_REQ'(1) << pick_idx;
            EN    <= 1'b1;
            S     <= pick_idx;
            BUSY  <= 1'b1;
            last  <= pick_idx;
`ifdef MUX_ARB_TIMEOUT_EN
            hold_cnt <= '0;
`endif
        end else begin
            // Nothing requested: go idle, keep LAST for the next pick.
            state <= IDLE;
            GNT   <= '0;
            EN    <= 1'b0;
            S     <= '0;
            BUSY  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_arb.sv
// Self-checking bench for mux_arb: vector table, directed corner sequences, random vs model.
// Latency: expects outputs one edge after inputs are sampled.
// Backpressure: n/a; honours MUX_ARB_TIMEOUT_EN when defined.
module tb_mux_arb;

    localparam int HOLD = 2;
`ifdef MUX_ARB_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [3:0] REQ = 4'b0000;
    logic [3:0] GNT;
    logic       EN;
    logic [1:0] S;
    logic       BUSY;

    int checks = 0;
    int errors = 0;

    // Reference model state: current holder (-1 idle), last grant, cycles held.
    int m_cur  = -1;
    int m_last = 3;
    int m_held = 0;

    mux_arb #(.HOLD_MAX(HOLD), .CNT_W(4)) dut (
        .CLK  (CLK),
        .RST  (RST),
        .REQ  (REQ),
        .GNT  (GNT),
        .EN   (EN),
        .S    (S),
        .BUSY (BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0] req;
        logic       rst;
        logic [3:0] gnt;
        logic [1:0] s;
        logic       en;
        logic       busy;
    } vec_t;

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_outs(input string tag, input logic [3:0] eg, input logic [1:0] es,
                            input logic een, input logic eb);
        chk({tag, ".gnt"}, GNT, eg);
        chk({tag, ".s"}, {2'b00, S}, {2'b00, es});
        chk({tag, ".en"}, {3'b000, EN}, {3'b000, een});
        chk({tag, ".busy"}, {3'b000, BUSY}, {3'b000, eb});
    endtask

    // Behaviour from the arbitration rules: keep a live holder, otherwise
    // scan LAST+1..LAST+4 (mod 4) for the first requester.
    task automatic model_step(input logic [3:0] r, input logic rs);
        int  nxt;
        bit  others;
        if (rs) begin
            m_cur  = -1;
            m_last = 3;
            m_held = 0;
            return;
        end
        others = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (r[i] && i != m_cur) others = 1'b1;
        end
        if (m_cur >= 0 && r[m_cur] && !(TMO && m_held >= HOLD - 1 && others)) begin
            if (m_held < HOLD - 1) m_held++;
            return;
        end
        nxt = -1;
        for (int off = 1; off <= 4; off++) begin
            if (nxt < 0 && r[(m_last + off) % 4]) nxt = (m_last + off) % 4;
        end
        m_cur = nxt;
        if (nxt >= 0) begin
            m_last = nxt;
            m_held = 0;
        end
    endtask

    // Apply one cycle of inputs, advance the model, sample #1 after the edge.
    task automatic cycle(input logic [3:0] r, input logic rs);
        REQ = r;
        RST = rs;
        @(posedge CLK);
        model_step(r, rs);
        #1;
    endtask

    task automatic chk_model(input string tag);
        logic [3:0] eg;
        logic [1:0] es;
        eg = (m_cur < 0) ? 4'b0000 : 4'(1 << m_cur);
        es = (m_cur < 0) ? 2'd0 : 2'(m_cur);
        chk_outs(tag, eg, es, m_cur >= 0, m_cur >= 0);
    endtask

    vec_t       tbl [15];
    logic [3:0] rot_exp [9];

    initial begin
        // reset, idle, single pulse, hand-off, reset mid-grant
        tbl[0]  = '{4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
        tbl[1]  = '{4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
        tbl[2]  = '{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};
        tbl[3]  = '{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};
        tbl[4]  = '{4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b1};
        tbl[5]  = '{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};
        tbl[6]  = '{4'b1001, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b1}; // LAST=2 retained
        tbl[7]  = '{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};
        tbl[8]  = '{4'b0011, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b1};
        tbl[9]  = '{4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b1}; // no idle gap
        tbl[10] = '{4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b1};
        tbl[11] = '{4'b1000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0}; // reset mid-grant
        tbl[12] = '{4'b1001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b1};
        tbl[13] = '{4'b1001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b1};
        tbl[14] = '{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};

        for (int i = 0; i < 15; i++) begin
            cycle(tbl[i].req, tbl[i].rst);
            chk_outs($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].s, tbl[i].en, tbl[i].busy);
        end

        // All four requesting after reset: rotation with timeout, else 0 holds.
        if (TMO) rot_exp = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100,
                             4'b0100, 4'b1000, 4'b1000, 4'b0001};
        else     rot_exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001,
                             4'b0001, 4'b0001, 4'b0001, 4'b0001};
        cycle(4'b0000, 1'b1);
        cycle(4'b0000, 1'b1);
        for (int i = 0; i < 9; i++) begin
            cycle(4'b1111, 1'b0);
            chk($sformatf("rot%0d.gnt", i), GNT, rot_exp[i]);
        end

        // Lone requester held for 20 cycles never loses the grant.
        cycle(4'b0000, 1'b0);
        for (int i = 0; i < 20; i++) begin
            cycle(4'b0001, 1'b0);
            chk($sformatf("solo%0d.gnt", i), GNT, 4'b0001);
        end

        // Drop and re-raise while granted: grant lost for the low cycle.
        cycle(4'b0000, 1'b0);
        chk("drop.gnt", GNT, 4'b0000);
        cycle(4'b0001, 1'b0);
        chk("reraise.gnt", GNT, 4'b0001);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] r;
            logic       rs;
            r  = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
            rs = ($urandom_range(0, 63) == 0);
            cycle(r, rs);
            chk_model($sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_arb.md
MUX_ARB -- requirements
Module: mux_arb

Interface
REQ-001 SHALL have parameter HOLD_MAX, default 8: maximum consecutive grant cycles per requester while others wait (timeout build only).
REQ-002 SHALL have parameter CNT_W, default 4: hold-counter width; HOLD_MAX SHALL be ≤ 2^CNT_W.
REQ-003 SHALL have port CLK, input, 1 bit: single clock; all state changes on rising edge.
REQ-004 SHALL have port RST, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port REQ, input, 4 bits: REQ[i]=1 means requester i wants the shared 4-way mux output.
REQ-006 SHALL have port GNT, output, 4 bits: one-hot grant, or all-zero when idle.
REQ-007 SHALL have port EN, output, 1 bit: mux enable, equal to |GNT.
REQ-008 SHALL have port S, output, 2 bits: mux select, equal to the index of the granted requester.
REQ-009 SHALL have port BUSY, output, 1 bit: 1 while in state GRANT.

Function
REQ-010 SHALL implement a two-state FSM: IDLE and GRANT.
REQ-011 All outputs SHALL be registered, with 1-cycle latency: REQ sampled at edge t takes effect on GNT/EN/S after edge t.
REQ-012 SHALL keep a pointer LAST (2 bits) holding the index of the most recent grant.
REQ-013 Round-robin pick SHALL search indices LAST+1, LAST+2, LAST+3, LAST (mod 4) and take the first with REQ=1.
REQ-014 IDLE with REQ=0000 SHALL stay IDLE with GNT=0000, EN=0, S=00.
REQ-015 IDLE with REQ≠0000 SHALL go to GRANT, grant the picked index, load LAST with that index, and clear the hold counter.
REQ-016 GRANT with REQ[cur]=1 SHALL keep the grant; the hold counter SHALL increment and saturate at HOLD_MAX-1.
REQ-017 GRANT with REQ[cur]=0 and other REQ pending SHALL re-arbitrate in the same edge and move directly to the new grant, with no idle cycle.
REQ-018 GRANT with REQ[cur]=0 and no other REQ SHALL go to IDLE (GNT=0000, EN=0, S=00); LAST SHALL be retained.
REQ-019 GNT SHALL never have more than one bit set, and SHALL never change except at a clock edge.
REQ-020 A requester that deasserts and reasserts REQ while granted SHALL lose the grant for the cycle REQ was low.
REQ-021 If all four request together, the grant order SHALL rotate 0→1→2→3→0 after reset.

Reset
REQ-022 RST=1 at an edge SHALL force: state IDLE, GNT=0000, EN=0, S=00, BUSY=0, hold counter 0, LAST=3 (index 0 has top priority).
REQ-023 RST SHALL override all REQ activity, including mid-grant; the first grant after RST falls SHALL follow REQ-013 with LAST=3.

Configuration
REQ-024 Macro MUX_ARB_TIMEOUT_EN defined: GRANT with REQ[cur]=1, hold counter = HOLD_MAX-1, and another REQ pending SHALL force rotation to the next picked requester.
REQ-025 With MUX_ARB_TIMEOUT_EN defined, rotation SHALL NOT occur when no other requester is pending; the grant is kept.
REQ-026 Macro MUX_ARB_TIMEOUT_EN undefined: the hold counter SHALL be absent and a grant SHALL persist until its REQ drops; HOLD_MAX and CNT_W are ignored.

Structure
REQ-027 Shared package mux_arb_pkg SHALL hold the state encoding (IDLE=0, GRANT=1), the requester count (4), the index width (2), and the reset value of LAST (3).
REQ-028 The round-robin selection SHALL be a combinational sub-module rr_pick.
  - inputs: REQ[3:0], LAST[1:0]
  - outputs: VALID, IDX[1:0]
  - instantiated once in mux_arb.

Verification
REQ-029 SHALL cover: RST=1 for 2 cycles, then REQ=0000 → GNT=0000, EN=0, S=00, BUSY=0 throughout.
REQ-030 SHALL cover: after reset, REQ=1111 held, timeout build, HOLD_MAX=2 → GNT sequence 0001,0001,0010,0010,0100,0100,1000,1000,0001; S tracks 0,0,1,1,2,2,3,3,0.
REQ-031 SHALL cover: REQ=0100 one cycle, then REQ=0000 → GNT=0100, S=10, EN=1 for one cycle, then IDLE with LAST=2.
REQ-032 SHALL cover: grant on 0 with REQ=0011, then REQ[0] drops → next cycle GNT=0010, S=01 (no idle gap).
REQ-033 SHALL cover: REQ=0001 held 20 cycles, timeout build, HOLD_MAX=8 → GNT stays 0001 for all 20 cycles (no rotation without competitor).
REQ-034 SHALL cover: RST asserted while GNT=1000 → next edge GNT=0000; after release with REQ=1001, first GNT=0001.
